mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL take parameter TIMEOUT, default 32, the maximum cycles to wait for completion from the memory.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-004 The block SHALL have the following CPU-side ports:
- req, input, 1 bit: access request, sampled in IDLE only.
- we, input, 1 bit: 1 = store, 0 = load.
- size, input, 2 bits: 00 byte, 01 halfword, 10 word, 11 reserved.
- sign_ext, input, 1 bit: 1 = sign-extend byte/half loads, 0 = zero-extend.
- addr, input, 32 bits: byte address.
- wdata, input, 32 bits: store data, right-justified.
- rdata, output, 32 bits: formatted load result.
- busy, output, 1 bit: high in any state other than IDLE.
- done, output, 1 bit: one-cycle completion pulse.
- err, output, 1 bit: one-cycle error pulse, coincident with done.
REQ-005 The block SHALL have the following memory-side ports:
- mem_en, output, 1 bit: operation valid.
- mem_rw, output, 1 bit: 1 = read, 0 = write.
- mem_addr, output, 32 bits: word-aligned address, {addr[31:2],2'b00}.
- mem_be, output, 4 bits: byte enables; bit3 is lane [31:24].
- mem_din, output, 32 bits: lane-positioned write data.
- mem_dout, input, 32 bits: read data.
- mem_moc, input, 1 bit: memory operation complete; idles high, low while busy.

Function
REQ-006 States SHALL be IDLE, START, WAIT, FIN, ERR, one-hot or binary.
REQ-007 IDLE with req=1 and an aligned access SHALL capture addr, size, we, sign_ext and wdata, then go to START next cycle.
- Aligned: byte, any address; half, addr[0]=0; word, addr[1:0]=0.
REQ-008 IDLE with req=1 and a misaligned access or size=11 SHALL go to ERR with no memory activity (mem_en stays 0).
REQ-009 START SHALL drive mem_en=1 and go to WAIT when mem_moc=0.
REQ-010 WAIT SHALL hold mem_en=1 and go to FIN when mem_moc=1, latching mem_dout that cycle.
REQ-011 FIN SHALL last one cycle, pulse done=1, present rdata, and return to IDLE.
REQ-012 ERR SHALL last one cycle, pulse done=1 and err=1, leave rdata unchanged, and return to IDLE.
REQ-013 A cycle counter SHALL clear on entry to START and increment each cycle in START or WAIT.
- On reaching TIMEOUT-1 without the exit condition, next state SHALL be ERR and mem_en SHALL drop.
REQ-014 Byte lanes SHALL be big-endian: addr[1:0]=00 maps to [31:24], 11 maps to [7:0].
REQ-015 mem_be SHALL be as follows, and 0000 whenever mem_en=0:
- byte: one-hot per the lane.
- half: 1100 (addr[1]=0) or 0011 (addr[1]=1).
- word: 1111.
REQ-016 mem_din SHALL replicate wdata[7:0] into all 4 lanes (byte) or wdata[15:0] into both halves (half).
REQ-017 For loads, rdata SHALL be the selected lane(s), right-justified, extended per sign_ext; word loads pass through unmodified.
REQ-018 Stores SHALL leave rdata unchanged.
REQ-019 mem_rw SHALL equal ~we_captured while mem_en=1, and 1 otherwise.
REQ-020 mem_addr, mem_be, mem_din and mem_rw SHALL stay stable from START through WAIT.
REQ-021 req asserted while busy=1 SHALL be ignored, not queued.
REQ-022 Minimum latency SHALL be 3 cycles from the req sample to done (mem_moc drops in START, rises in the first WAIT cycle).
REQ-023 If mem_moc=0 already holds in IDLE, START SHALL still exit to WAIT on it, with no deadlock.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, with rdata, done, err, mem_en, mem_be and the counter at 0, mem_rw=1, and mem_addr/mem_din at 0.
REQ-025 Reset mid-operation SHALL abort the access: no done pulse, and mem_en drops asynchronously.

Verification
REQ-026 Load byte test: word 0x80FF1234 at 0x10, load byte addr 0x11 with sign_ext=1 -> rdata=0xFFFFFFFF, mem_be=0100, done after 3 cycles.
REQ-027 Load half test: same word, addr 0x12, sign_ext=0 -> rdata=0x00001234, mem_be=0011.
REQ-028 Store byte test: wdata=0x000000AB, addr 0x23 -> mem_din=0xABABABAB, mem_be=0001, mem_rw=0; the memory word then reads back with low byte 0xAB.
REQ-029 Misaligned word test: load addr 0x06 -> err=1 and done=1 exactly one cycle after req, mem_en never asserted.
REQ-030 Timeout test: mem_moc held at 1, TIMEOUT=8 -> err pulse 8 cycles after entering START, then busy=0.
REQ-031 Reset test: rst_n pulled low in WAIT -> mem_en=0 in the same cycle, no done; a fresh load after release completes normally.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// CPU-side and memory-side signal bundle for mem_access_ctrl.
// slave is the controller's view; master is the CPU/memory environment's view.
interface mem_access_ctrl_if;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        busy;
   logic        done;
   logic        err;

   logic        mem_en;
   logic        mem_rw;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;
   logic        mem_moc;

   modport slave (
      input  req, we, size, sign_ext, addr, wdata, mem_dout, mem_moc,
      output rdata, busy, done, err, mem_en, mem_rw, mem_addr, mem_be, mem_din
   );

   modport master (
      output req, we, size, sign_ext, addr, wdata, mem_dout, mem_moc,
      input  rdata, busy, done, err, mem_en, mem_rw, mem_addr, mem_be, mem_din
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Byte/half/word load-store controller bridging a CPU request to a handshaked
// big-endian 32-bit memory, with alignment checking and a completion timeout.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT = 32
) (
   input logic              clk,
   input logic              rst_n,
   mem_access_ctrl_if.slave bus
);
   localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {StIdle, StStart, StWait, StFin, StErr} state_e;

   state_e          state_q, state_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [1:0]      size_q, size_d;
   logic            we_q, we_d;
   logic            sext_q, sext_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic            aligned;
   logic            timeout;
   logic            active;
   logic [7:0]      lane_b;
   logic [15:0]     lane_h;
   logic [31:0]     load_fmt;
   logic [3:0]      be;
   logic [31:0]     din;

   always_comb begin
      aligned = 1'b0;
      unique case (bus.size)
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~bus.addr[0];
         2'b10:   aligned = (bus.addr[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   assign timeout = (cnt_q == CntW'(TIMEOUT - 1));
   assign active  = (state_q == StStart) || (state_q == StWait);

   // Big-endian lanes: offset 0 is the most significant byte.
   always_comb begin
      lane_b = 8'h00;
      unique case (addr_q[1:0])
         2'b00: lane_b = bus.mem_dout[31:24];
         2'b01: lane_b = bus.mem_dout[23:16];
         2'b10: lane_b = bus.mem_dout[15:8];
         2'b11: lane_b = bus.mem_dout[7:0];
      endcase
      lane_h = addr_q[1] ? bus.mem_dout[15:0] : bus.mem_dout[31:16];
      case (size_q)
         2'b00:   load_fmt = {{24{sext_q & lane_b[7]}}, lane_b};
         2'b01:   load_fmt = {{16{sext_q & lane_h[15]}}, lane_h};
         default: load_fmt = bus.mem_dout;
      endcase
   end

   always_comb begin
      case (size_q)
         2'b00:   be = 4'b1000 >> addr_q[1:0];
         2'b01:   be = addr_q[1] ? 4'b0011 : 4'b1100;
         default: be = 4'b1111;
      endcase
      case (size_q)
         2'b00:   din = {4{wdata_q[7:0]}};
         2'b01:   din = {2{wdata_q[15:0]}};
         default: din = wdata_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      we_d    = we_q;
      sext_d  = sext_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      case (state_q)
         StIdle: begin
            if (bus.req) begin
               if (aligned) begin
                  addr_d  = bus.addr;
                  wdata_d = bus.wdata;
                  size_d  = bus.size;
                  we_d    = bus.we;
                  sext_d  = bus.sign_ext;
                  cnt_d   = '0;
                  state_d = StStart;
               end else begin
                  state_d = StErr;
               end
            end
         end
         StStart: begin
            cnt_d = cnt_q + CntW'(1);
            if (!bus.mem_moc) begin
               state_d = StWait;
            end else if (timeout) begin
               state_d = StErr;
            end
         end
         StWait: begin
            cnt_d = cnt_q + CntW'(1);
            if (bus.mem_moc) begin
               state_d = StFin;
               if (!we_q) begin
                  rdata_d = load_fmt;
               end
            end else if (timeout) begin
               state_d = StErr;
            end
         end
         StFin:   state_d = StIdle;
         StErr:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         size_q  <= '0;
         we_q    <= 1'b0;
         sext_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         size_q  <= size_d;
         we_q    <= we_d;
         sext_q  <= sext_d;
         cnt_q   <= cnt_d;
      end
   end

   // Memory outputs decode straight from state so reset drops mem_en immediately.
   assign bus.mem_en   = active;
   assign bus.mem_rw   = active ? ~we_q : 1'b1;
   assign bus.mem_addr = {addr_q[31:2], 2'b00};
   assign bus.mem_be   = active ? be : 4'b0000;
   assign bus.mem_din  = din;
   assign bus.rdata    = rdata_q;
   assign bus.busy     = (state_q != StIdle);
   assign bus.done     = (state_q == StFin) || (state_q == StErr);
   assign bus.err      = (state_q == StErr);
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases plus randomized accesses
// checked against a word-array memory model and arithmetic lane rules.
module tb_mem_access_ctrl;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   mem_access_ctrl_if bus ();

   mem_access_ctrl #(.TIMEOUT(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem [64];
   logic [31:0] ref_mem [64];
   logic [31:0] exp_rdata;

   // Memory responder controls
   int          lat;
   bit          stall;
   bit          hold_low;
   bit          en_seen;
   int          unstable;
   bit          r_busy;
   bit          r_served;
   int          r_cnt;
   logic [3:0]  s_be;
   logic [31:0] s_din;
   logic [31:0] s_addr;
   logic        s_rw;

   always @(negedge clk) begin
      if (!bus.mem_en) begin
         r_busy   = 1'b0;
         r_served = 1'b0;
         bus.mem_moc = hold_low ? 1'b0 : 1'b1;
      end else begin
         en_seen = 1'b1;
         if (!r_busy && !r_served) begin
            if (!stall) begin
               r_busy = 1'b1;
               r_cnt  = lat;
               bus.mem_moc = 1'b0;
               s_be   = bus.mem_be;
               s_din  = bus.mem_din;
               s_addr = bus.mem_addr;
               s_rw   = bus.mem_rw;
            end
         end else if (r_busy) begin
            if (bus.mem_be !== s_be || bus.mem_din !== s_din ||
                bus.mem_addr !== s_addr || bus.mem_rw !== s_rw) unstable++;
            r_cnt--;
            if (r_cnt == 0) begin
               if (bus.mem_rw) begin
                  bus.mem_dout = mem[bus.mem_addr[7:2]];
               end else begin
                  for (int b = 0; b < 4; b++)
                     if (bus.mem_be[b]) mem[bus.mem_addr[7:2]][8*b +: 8] = bus.mem_din[8*b +: 8];
               end
               bus.mem_moc = 1'b1;
               r_busy   = 1'b0;
               r_served = 1'b1;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One access with full model checking. itimeout marks accesses expected to time out.
   task automatic run_op(input string tag, input logic iwe, input logic [1:0] isz,
                         input logic isx, input logic [31:0] iad, input logic [31:0] iwd,
                         input int ilat, input bit istall, input bit itimeout, input bit ipulse);
      int          cyc;
      int          off;
      int          sh;
      bit          misal;
      logic [31:0] w;
      logic [31:0] v;
      logic [31:0] e_din;
      logic [3:0]  e_be;
      off   = int'(iad[1:0]);
      misal = (isz == 2'd3) || (isz == 2'd1 && iad[0]) || (isz == 2'd2 && iad[1:0] != 2'b00);
      @(negedge clk);
      lat = ilat;
      stall = istall;
      en_seen = 1'b0;
      unstable = 0;
      bus.we = iwe; bus.size = isz; bus.sign_ext = isx; bus.addr = iad; bus.wdata = iwd;
      bus.req = 1'b1;
      @(posedge clk);
      cyc = 1;
      @(negedge clk);
      bus.req = 1'b0;
      while (!bus.done && cyc < 64) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         bus.req = (ipulse && cyc == 2) ? 1'b1 : 1'b0;
      end
      bus.req = 1'b0;
      chk({tag, "_done"}, 32'(bus.done), 32'd1);
      chk({tag, "_lat"}, cyc, misal ? 1 : (itimeout ? 9 : 2 + ilat));
      chk({tag, "_err"}, 32'(bus.err), 32'(misal || itimeout));
      chk({tag, "_en_seen"}, 32'(en_seen), 32'(!misal));
      if (!misal && !itimeout) begin
         case (isz)
            2'd0:    begin e_be = 4'(1 << (3 - off)); e_din = (iwd & 32'hFF) * 32'h01010101; end
            2'd1:    begin e_be = iad[1] ? 4'd3 : 4'd12; e_din = (iwd & 32'hFFFF) * 32'h00010001; end
            default: begin e_be = 4'd15; e_din = iwd; end
         endcase
         chk({tag, "_be"}, 32'(s_be), 32'(e_be));
         chk({tag, "_rw"}, 32'(s_rw), 32'(!iwe));
         chk({tag, "_addr"}, s_addr, iad & ~32'd3);
         if (iwe) chk({tag, "_din"}, s_din, e_din);
         chk({tag, "_stable"}, unstable, 0);
         w = ref_mem[iad[7:2]];
         if (iwe) begin
            case (isz)
               2'd0: begin
                  sh = 8 * (3 - off);
                  w = (w & ~(32'hFF << sh)) | ((iwd & 32'hFF) << sh);
               end
               2'd1: begin
                  sh = iad[1] ? 0 : 16;
                  w = (w & ~(32'hFFFF << sh)) | ((iwd & 32'hFFFF) << sh);
               end
               default: w = iwd;
            endcase
            ref_mem[iad[7:2]] = w;
            chk({tag, "_memword"}, mem[iad[7:2]], w);
         end else begin
            case (isz)
               2'd0: begin
                  v = (w >> (8 * (3 - off))) & 32'hFF;
                  if (isx && v >= 32'h80) v = v | 32'hFFFFFF00;
               end
               2'd1: begin
                  v = (w >> (iad[1] ? 0 : 16)) & 32'hFFFF;
                  if (isx && v >= 32'h8000) v = v | 32'hFFFF0000;
               end
               default: v = w;
            endcase
            exp_rdata = v;
         end
      end
      chk({tag, "_rdata"}, bus.rdata, exp_rdata);
      @(negedge clk);
      chk({tag, "_idle_after"}, {30'd0, bus.busy, bus.done}, 32'd0);
   endtask

   initial begin
      int done_seen;
      checks = 0;
      failures = 0;
      lat = 1; stall = 1'b0; hold_low = 1'b0; en_seen = 1'b0; unstable = 0;
      r_busy = 1'b0; r_served = 1'b0; r_cnt = 0;
      bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'd0; bus.sign_ext = 1'b0;
      bus.addr = '0; bus.wdata = '0;
      for (int i = 0; i < 64; i++) begin
         mem[i] = $urandom;
         ref_mem[i] = mem[i];
      end
      mem[4] = 32'h80FF1234;
      ref_mem[4] = 32'h80FF1234;
      exp_rdata = 32'd0;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done_err", {30'd0, bus.done, bus.err}, 32'd0);
      chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
      chk("rst_mem_rw", 32'(bus.mem_rw), 32'd1);
      chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_din", bus.mem_din, 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      rst_n = 1'b1;

      run_op("ldb_sx", 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 1, 1'b0, 1'b0, 1'b0);
      chk("ldb_sx_value", bus.rdata, 32'hFFFFFFFF);
      run_op("ldh_zx", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1, 1'b0, 1'b0, 1'b0);
      chk("ldh_zx_value", bus.rdata, 32'h00001234);
      run_op("stb", 1'b1, 2'd0, 1'b0, 32'h23, 32'h000000AB, 2, 1'b0, 1'b0, 1'b0);
      run_op("ldw_back", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1, 1'b0, 1'b0, 1'b0);
      chk("ldw_back_lowbyte", 32'(bus.rdata[7:0]), 32'hAB);
      run_op("misal_w", 1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 1, 1'b0, 1'b0, 1'b0);
      run_op("rsvd_size", 1'b1, 2'd3, 1'b0, 32'h40, 32'h5, 1, 1'b0, 1'b0, 1'b0);
      run_op("to_start", 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1, 1'b1, 1'b1, 1'b0);
      run_op("to_wait", 1'b1, 2'd2, 1'b0, 32'h34, 32'h1234, 12, 1'b0, 1'b1, 1'b0);
      run_op("max_wait", 1'b0, 2'd2, 1'b0, 32'h38, 32'h0, 7, 1'b0, 1'b0, 1'b0);

      hold_low = 1'b1;
      @(negedge clk);
      run_op("moc_low_idle", 1'b0, 2'd1, 1'b1, 32'h4C, 32'h0, 2, 1'b0, 1'b0, 1'b0);
      hold_low = 1'b0;

      // Abort a load mid-WAIT with an asynchronous reset.
      @(negedge clk);
      lat = 8; stall = 1'b0;
      bus.we = 1'b0; bus.size = 2'd2; bus.sign_ext = 1'b0; bus.addr = 32'h40; bus.req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid_pre_en", 32'(bus.mem_en), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_mem_en", 32'(bus.mem_en), 32'd0);
      chk("rst_mid_busy", 32'(bus.busy), 32'd0);
      chk("rst_mid_rdata", bus.rdata, 32'd0);
      exp_rdata = 32'd0;
      done_seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.done) done_seen++;
         if (i == 2) rst_n = 1'b1;
      end
      chk("rst_mid_no_done", done_seen, 0);
      run_op("post_rst", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1, 1'b0, 1'b0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         run_op("rnd", 1'(($urandom & 1)), 2'($urandom_range(3, 0)), 1'(($urandom & 1)),
                32'($urandom_range(255, 0)), $urandom, int'($urandom_range(4, 1)),
                1'b0, 1'b0, 1'(($urandom & 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=no_finish expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
